// File: rtl/sr_drive_pkg.sv
// Shared types and constants for the set/reset latch driver.
// The CHECK state exists only when SR_DRIVE_READBACK_EN is defined.
package sr_drive_pkg;

  localparam int CNT_W       = 8;
  localparam int PULSE_W_DEF = 4;
  localparam int GAP_W_DEF   = 2;

`ifdef SR_DRIVE_READBACK_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    CHECK = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_e;
`endif

endpackage

// File: rtl/sr_pulse_timer.sv
// Loadable down-counter shared by the pulse and dead-time phases.
// done is high while the count sits at zero; the counter holds there.
module sr_pulse_timer
  import sr_drive_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/sr_drive_ctrl.sv
// Pulse sequencer for an external SR latch: one S or R pulse per command, then dead time.
// Define SR_DRIVE_READBACK_EN to add a Q/Q-bar readback check with a sticky err flag.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for cmd_valid
// PULSE | s or r held high for PULSE_W cycles
// GAP   | s and r low for GAP_W cycles (skipped when GAP_W is 0)
// CHECK | one cycle comparing latch readback to the command (readback builds only)
module sr_drive_ctrl
  import sr_drive_pkg::*;
#(
  parameter int PULSE_W = PULSE_W_DEF,
  parameter int GAP_W   = GAP_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic cmd_valid,
  input  logic cmd_set,
  output logic cmd_ready,
  output logic s,
  output logic r,
  output logic busy,
  input  logic q_in,
  input  logic qbar_in,
  input  logic err_clr,
  output logic err
);

  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_W - 1);

`ifdef SR_DRIVE_READBACK_EN
  localparam state_e POST_STATE = CHECK;
`else
  localparam state_e POST_STATE = IDLE;
`endif

  state_e           state;
  logic             cmd_q;
  logic             accept;
  logic             load;
  logic             done;
  logic [CNT_W-1:0] load_val;

  assign accept    = (state == IDLE) && cmd_valid;
  assign load      = accept || ((state == PULSE) && done && (GAP_W != 0));
  assign load_val  = accept ? PULSE_LD : GAP_LD;
  assign cmd_ready = (state == IDLE);
  assign busy      = ~cmd_ready;

  sr_pulse_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .done     (done)
  );

  // s and r are only ever loaded as a complementary pair or both cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      s     <= 1'b0;
      r     <= 1'b0;
      cmd_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            state <= PULSE;
            cmd_q <= cmd_set;
            s     <= cmd_set;
            r     <= ~cmd_set;
          end
        end
        PULSE: begin
          if (done) begin
            s     <= 1'b0;
            r     <= 1'b0;
            state <= (GAP_W != 0) ? GAP : POST_STATE;
          end
        end
        GAP: begin
          if (done) state <= POST_STATE;
        end
`ifdef SR_DRIVE_READBACK_EN
        CHECK: state <= IDLE;
`endif
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SR_DRIVE_READBACK_EN
  logic err_q;

  // Good readback is the only path that avoids setting err, so an unknown
  // comparison lands in the set branch; a set beats a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state == CHECK) begin
      if ((q_in == cmd_q) && (qbar_in != cmd_q)) err_q <= err_q & ~err_clr;
      else                                       err_q <= 1'b1;
    end else if (err_clr) begin
      err_q <= 1'b0;
    end
  end

  assign err = err_q;
`else
  logic unused_rb;
  assign unused_rb = ^{q_in, qbar_in, err_clr, cmd_q};
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// Directed bench for sr_drive_ctrl: default-parameter instance plus a PULSE_W=1/GAP_W=0 instance.
// Expected periods follow SR_DRIVE_READBACK_EN when the bench is built with it.
module tb_sr_drive_ctrl;

`ifdef SR_DRIVE_READBACK_EN
  localparam int   PER     = 8;
  localparam int   PER1    = 3;
  localparam logic ERR_EXP = 1'b1;
`else
  localparam int   PER     = 7;
  localparam int   PER1    = 2;
  localparam logic ERR_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_set = 1'b0, err_clr = 1'b0;
  logic q_in, qbar_in, q_m = 1'b0, force_bad = 1'b0;
  logic cmd_ready, s, r, busy, err;
  logic v1 = 1'b0, set1 = 1'b0, q1 = 1'b0, qb1 = 1'b1, clr1 = 1'b0;
  logic rdy1, s1, r1, busy1, err1;

  int n_cmp = 0, n_bad = 0, overlap = 0;
  int s_cnt, r_cnt, s_first, r_first, r_rise2, rdy_first;

  always #5 clk = ~clk;

  // Behavioural latch so readback builds see a correct Q unless forced bad.
  always @(posedge clk) begin
    if (s)      q_m <= 1'b1;
    else if (r) q_m <= 1'b0;
  end
  assign q_in    = force_bad ? 1'b0 : q_m;
  assign qbar_in = force_bad ? 1'b1 : ~q_m;

  always @(negedge clk) begin
    if ((s && r) || (s1 && r1)) overlap++;
  end

  sr_drive_ctrl u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_set(cmd_set),
    .cmd_ready(cmd_ready), .s(s), .r(r), .busy(busy),
    .q_in(q_in), .qbar_in(qbar_in), .err_clr(err_clr), .err(err)
  );

  sr_drive_ctrl #(.PULSE_W(1), .GAP_W(0)) u_dut1 (
    .clk(clk), .rst(rst), .cmd_valid(v1), .cmd_set(set1),
    .cmd_ready(rdy1), .s(s1), .r(r1), .busy(busy1),
    .q_in(q1), .qbar_in(qb1), .err_clr(clr1), .err(err1)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && !cmd_ready; i++) tick();
    chk("idle_timeout", int'(cmd_ready), 1);
  endtask

  // Index i is sampled just after the (i+1)-th edge; index 0 follows the accepting edge.
  task automatic observe(input int n, input bit drop);
    logic prev_r;
    int   rises;
    prev_r = 1'b0; rises = 0;
    s_cnt = 0; r_cnt = 0; s_first = -1; r_first = -1; r_rise2 = -1; rdy_first = -1;
    for (int i = 0; i < n; i++) begin
      tick();
      if (i == 0 && drop) cmd_valid = 1'b0;
      if (s) begin s_cnt++; if (s_first < 0) s_first = i; end
      if (r) begin r_cnt++; if (r_first < 0) r_first = i; end
      if (r && !prev_r) begin rises++; if (rises == 2) r_rise2 = i; end
      if (cmd_ready && rdy_first < 0) rdy_first = i;
      prev_r = r;
    end
  endtask

  initial begin
    int sc, rc, r1_first, s1c, r1c;

    #1;
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_busy",  int'(busy), 0);
    chk("rst_sr",    int'({s, r}), 0);
    chk("rst_err",   int'(err), 0);
    tick(); tick();
    rst = 1'b0;

    // Single set command, one-cycle valid
    cmd_valid = 1'b1; cmd_set = 1'b1;
    observe(12, 1'b1);
    chk("set_s_cnt",   s_cnt, 4);
    chk("set_s_first", s_first, 0);
    chk("set_r_cnt",   r_cnt, 0);
    chk("set_ready",   rdy_first, PER - 1);

    // Reset commands with valid held high
    cmd_set = 1'b0; cmd_valid = 1'b1;
    observe(3 * PER, 1'b0);
    cmd_valid = 1'b0;
    chk("rep_r_cnt",   r_cnt, 12);
    chk("rep_s_cnt",   s_cnt, 0);
    chk("rep_r_first", r_first, 0);
    chk("rep_period",  r_rise2, PER);
    wait_idle();

    // Reset in the 2nd cycle of an s pulse
    cmd_valid = 1'b1; cmd_set = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("mid_s_1st", int'(s), 1);
    tick();
    chk("mid_s_2nd", int'(s), 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_s",     int'(s), 0);
    chk("mid_rst_r",     int'(r), 0);
    chk("mid_rst_ready", int'(cmd_ready), 1);
    chk("mid_rst_busy",  int'(busy), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    cmd_valid = 1'b1; cmd_set = 1'b0;
    tick();
    cmd_valid = 1'b0;
    chk("post_rst_r",    int'(r), 1);
    chk("post_rst_s",    int'(s), 0);
    chk("post_rst_busy", int'(busy), 1);
    wait_idle();

    // Toggling valid while busy must not add pulses
    cmd_valid = 1'b1; cmd_set = 1'b1;
    tick();
    cmd_set = 1'b0;
    sc = int'(s); rc = int'(r);
    for (int i = 1; i < PER; i++) begin
      cmd_valid = (i % 2 == 1);
      tick();
      sc += int'(s); rc += int'(r);
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < PER; i++) begin
      tick();
      sc += int'(s); rc += int'(r);
    end
    chk("tog_s_cnt", sc, 4);
    chk("tog_r_cnt", rc, 0);

    // Bad readback then error clear
    force_bad = 1'b1;
    cmd_valid = 1'b1; cmd_set = 1'b1;
    tick();
    cmd_valid = 1'b0;
    wait_idle();
    chk("err_set", int'(err), int'(ERR_EXP));
    tick(); tick(); tick();
    chk("err_sticky", int'(err), int'(ERR_EXP));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_clr", int'(err), 0);
    force_bad = 1'b0;

    // PULSE_W=1, GAP_W=0: set then reset back-to-back
    v1 = 1'b1; set1 = 1'b1;
    tick();
    set1 = 1'b0;
    chk("w1_s_first", int'(s1), 1);
    chk("w1_r_first", int'(r1), 0);
    r1_first = -1; s1c = 0; r1c = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      s1c += int'(s1); r1c += int'(r1);
      if (r1 && r1_first < 0) begin
        r1_first = i;
        v1 = 1'b0;
      end
    end
    v1 = 1'b0;
    chk("w1_r_delay", r1_first, PER1);
    chk("w1_s_more",  s1c, 0);
    chk("w1_r_cnt",   r1c, 1);

    chk("no_overlap", overlap, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
